mesh_term_injector: RTL and testbench

//  Per-terminal injection stage sitting directly upstream of one mesh_gnrtr terminal port.
//  - Accepts packets from the host side (driver).
//  - Validates the target address and buffers valid packets in a first-word-fall-through FIFO.
//  - Presents them to the router via the pndng_i_in / data_out_i_in / popin handshake.
//  - Counts injected and dropped packets for scoreboard cross-checking.

---
 rtl/mesh_term_injector.sv | 99 +++++++++
 tb/tb_mesh_term_injector.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mesh_term_injector.sv
// Per-terminal injection stage: validates host packets, buffers them in a FWFT FIFO
// and presents them to one mesh router terminal port, with sent/dropped counters.
module mesh_term_injector #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMS     = 4,
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4,
  parameter logic [7:0]  bdcst      = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [pckg_sz-1:0] data_in,
  output logic               full,
  output logic               pndng_i_in,
  output logic [pckg_sz-1:0] data_out_i_in,
  input  logic               popin,
  output logic [15:0]        sent_cnt,
  output logic [15:0]        drop_cnt,
  output logic               overflow
);

  localparam int unsigned PW = $clog2(fifo_depth);
  localparam int unsigned CW = $clog2(fifo_depth + 1);
  localparam logic [PW-1:0] LastIdx = PW'(fifo_depth - 1);
  localparam logic [CW-1:0] DepthC  = CW'(fifo_depth);
  localparam logic [3:0] RowLast = 4'(ROWS);
  localparam logic [3:0] RowEdge = 4'(ROWS + 1);
  localparam logic [3:0] ColLast = 4'(COLUMS);
  localparam logic [3:0] ColEdge = 4'(COLUMS + 1);

  logic [pckg_sz-1:0] r_mem [fifo_depth];
  logic [PW-1:0]      r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]      r_count;
  logic [15:0]        r_sent, r_drop;
  logic               r_ovf;

  logic [3:0] w_row, w_col;
  logic       w_row_edge, w_col_edge, w_row_in, w_col_in;
  logic       w_valid, w_full, w_pop, w_push_acc, w_drop, w_lost;

  function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  assign w_row      = data_in[pckg_sz-9 -: 4];
  assign w_col      = data_in[pckg_sz-13 -: 4];
  assign w_row_edge = (w_row == 4'd0) || (w_row == RowEdge);
  assign w_col_edge = (w_col == 4'd0) || (w_col == ColEdge);
  assign w_row_in   = (w_row >= 4'd1) && (w_row <= RowLast);
  assign w_col_in   = (w_col >= 4'd1) && (w_col <= ColLast);
  // Terminals sit on exactly one edge of the mesh; corners have no router attached.
  assign w_valid    = ({w_row, w_col} == bdcst) || (w_row_edge && w_col_in) ||
                      (w_col_edge && w_row_in);

  assign w_full     = (r_count == DepthC);
  assign w_pop      = popin && (r_count != '0);
  assign w_push_acc = push && w_valid && (!w_full || popin);
  assign w_drop     = push && !w_valid;
  assign w_lost     = push && w_valid && w_full && !popin;

  assign full          = w_full;
  assign pndng_i_in    = (r_count != '0);
  assign data_out_i_in = pndng_i_in ? r_mem[r_rd_ptr] : '0;
  assign sent_cnt      = r_sent;
  assign drop_cnt      = r_drop;
  assign overflow      = r_ovf;

  always_ff @(posedge clk) begin
    if (reset && w_push_acc) begin
      r_mem[r_wr_ptr] <= {8'h00, data_in[pckg_sz-9:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_sent   <= '0;
      r_drop   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= f_nxt(r_rd_ptr);
        if (r_sent != 16'hFFFF) r_sent <= r_sent + 16'd1;
      end
      if (w_push_acc) r_wr_ptr <= f_nxt(r_wr_ptr);
      case ({w_push_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
      if (w_lost) r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mesh_term_injector.sv
// Directed and randomized checks of mesh_term_injector against a queue-based packet model.
module tb_mesh_term_injector;

  logic        clk = 1'b0;
  logic        reset, push, popin;
  logic [39:0] data_in;
  logic        full, pndng_i_in, overflow;
  logic [39:0] data_out_i_in;
  logic [15:0] sent_cnt, drop_cnt;

  always #5 clk = ~clk;

  mesh_term_injector #(
    .ROWS       (4),
    .COLUMS     (4),
    .pckg_sz    (40),
    .fifo_depth (4),
    .bdcst      (8'hFF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .data_in       (data_in),
    .full          (full),
    .pndng_i_in    (pndng_i_in),
    .data_out_i_in (data_out_i_in),
    .popin         (popin),
    .sent_cnt      (sent_cnt),
    .drop_cnt      (drop_cnt),
    .overflow      (overflow)
  );

  logic [39:0] m_q[$];
  int unsigned m_sent, m_drop;
  bit          m_ovf;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic logic [39:0] mk(input logic [7:0] nj, input logic [3:0] row,
                                     input logic [3:0] col, input logic [23:0] pay);
    return {nj, row, col, pay};
  endfunction

  // A terminal lies on exactly one border (row 0/5 or col 0/5) with the other index 1..4.
  function automatic bit tgt_ok(input logic [39:0] d);
    int r;
    int c;
    r = int'(d[31:28]);
    c = int'(d[27:24]);
    if (d[31:24] == 8'hFF) return 1'b1;
    if ((r == 0 || r == 5) && c >= 1 && c <= 4) return 1'b1;
    if ((c == 0 || c == 5) && r >= 1 && r <= 4) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_edge(input bit rst_n, input bit p, input logic [39:0] d, input bit pop);
    bit was_full;
    bit do_pop;
    if (!rst_n) begin
      m_q.delete();
      m_sent = 0;
      m_drop = 0;
      m_ovf  = 1'b0;
      return;
    end
    was_full = (m_q.size() == 4);
    do_pop   = pop && (m_q.size() != 0);
    if (do_pop) begin
      void'(m_q.pop_front());
      if (m_sent < 65535) m_sent++;
    end
    if (p) begin
      if (!tgt_ok(d)) begin
        if (m_drop < 65535) m_drop++;
      end else if (was_full && !pop) begin
        m_ovf = 1'b1;
      end else begin
        m_q.push_back({8'h00, d[31:0]});
      end
    end
  endtask

  task automatic check_all();
    chk("pndng", 40'(pndng_i_in), 40'(m_q.size() != 0));
    chk("data_out", data_out_i_in, (m_q.size() != 0) ? m_q[0] : 40'h0);
    chk("full", 40'(full), 40'(m_q.size() == 4));
    chk("sent_cnt", 40'(sent_cnt), 40'(m_sent));
    chk("drop_cnt", 40'(drop_cnt), 40'(m_drop));
    chk("overflow", 40'(overflow), 40'(m_ovf));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then sample after it.
  task automatic cyc(input bit rst_n, input bit p, input logic [39:0] d, input bit pop);
    reset   = rst_n;
    push    = p;
    data_in = d;
    popin   = pop;
    @(posedge clk);
    model_edge(rst_n, p, d, pop);
    #1;
    check_all();
  endtask

  initial begin
    logic [39:0] pk[5];
    logic [39:0] d;
    logic [3:0]  r4, c4;

    // 1: reset and a single packet round trip
    cyc(1'b0, 1'b0, 40'h0, 1'b0);
    chk("rst_pndng", 40'(pndng_i_in), 40'h0);
    chk("rst_dout", data_out_i_in, 40'h0);
    cyc(1'b1, 1'b1, 40'h00_51_5A_BCDE, 1'b0);
    chk("t1_pndng", 40'(pndng_i_in), 40'h1);
    chk("t1_dout", data_out_i_in, 40'h00_51_5A_BCDE);
    cyc(1'b1, 1'b0, 40'h0, 1'b1);
    chk("t1_empty", 40'(pndng_i_in), 40'h0);
    chk("t1_sent", 40'(sent_cnt), 40'h1);
    cyc(1'b1, 1'b0, 40'h0, 1'b1);
    chk("t1_pop_empty", 40'(sent_cnt), 40'h1);

    // 2: nxt_jump is cleared on store
    cyc(1'b1, 1'b1, mk(8'h3C, 4'd0, 4'd2, 24'h12_3456), 1'b0);
    chk("t2_dout", data_out_i_in, mk(8'h00, 4'd0, 4'd2, 24'h12_3456));
    cyc(1'b1, 1'b0, 40'h0, 1'b1);

    // 3: corner, out-of-range and interior targets are dropped
    cyc(1'b0, 1'b0, 40'h0, 1'b0);
    cyc(1'b1, 1'b1, mk(8'h01, 4'd0, 4'd0, 24'h1), 1'b0);
    cyc(1'b1, 1'b1, mk(8'h02, 4'd6, 4'd3, 24'h2), 1'b0);
    cyc(1'b1, 1'b1, mk(8'h03, 4'd2, 4'd2, 24'h3), 1'b0);
    chk("t3_drop", 40'(drop_cnt), 40'd3);
    chk("t3_pndng", 40'(pndng_i_in), 40'h0);
    chk("t3_ovf", 40'(overflow), 40'h0);

    // 4: fill, overflow, drain in order
    for (int i = 0; i < 5; i++) pk[i] = mk(8'(i), 4'd5, 4'(1 + i % 4), 24'(24'hA000 + i));
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, pk[i], 1'b0);
    chk("t4_full", 40'(full), 40'h1);
    cyc(1'b1, 1'b1, pk[4], 1'b0);
    chk("t4_ovf", 40'(overflow), 40'h1);
    chk("t4_head", data_out_i_in, {8'h00, pk[0][31:0]});
    chk("t4_drop_same", 40'(drop_cnt), 40'd3);
    for (int i = 0; i < 4; i++) begin
      chk("t4_order", data_out_i_in, {8'h00, pk[i][31:0]});
      cyc(1'b1, 1'b0, 40'h0, 1'b1);
    end
    chk("t4_notfull", 40'(full), 40'h0);

    // 5: push+pop on a full buffer, then broadcast target
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, pk[i], 1'b0);
    cyc(1'b1, 1'b1, mk(8'h77, 4'hF, 4'hF, 24'hB0B0B0), 1'b1);
    chk("t5_still_full", 40'(full), 40'h1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 40'h0, 1'b1);
    chk("t5_bcast_4th", data_out_i_in, mk(8'h00, 4'hF, 4'hF, 24'hB0B0B0));
    cyc(1'b1, 1'b0, 40'h0, 1'b1);

    // 6: reset during a popin discards everything
    cyc(1'b1, 1'b1, pk[0], 1'b0);
    cyc(1'b1, 1'b1, pk[1], 1'b0);
    cyc(1'b0, 1'b0, 40'h0, 1'b1);
    chk("t6_pndng", 40'(pndng_i_in), 40'h0);
    chk("t6_sent", 40'(sent_cnt), 40'h0);
    chk("t6_drop", 40'(drop_cnt), 40'h0);
    chk("t6_ovf", 40'(overflow), 40'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r4 = 4'($urandom_range(0, 6));
      c4 = 4'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) begin
        r4 = 4'hF;
        c4 = 4'hF;
      end
      d = mk(8'($urandom), r4, c4, 24'($urandom));
      cyc(($urandom_range(0, 60) != 0), ($urandom_range(0, 2) != 0), d,
          ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
